// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types and defaults for the clock-generator pearl and its frequency meter.
`timescale 1ps/1ps
package bsg_clk_gen_pearl_pkg;

    // Default widths for the frequency meter window and result count
    localparam int bsg_clk_gen_pearl_freq_window_width_gp = 16;
    localparam int bsg_clk_gen_pearl_freq_count_width_gp  = 16;

    // Frequency meter control states
    typedef enum logic [1:0] {
        e_freq_idle  = 2'd0,
        e_freq_arm   = 2'd1,
        e_freq_count = 2'd2,
        e_freq_done  = 2'd3
    } bsg_clk_gen_pearl_freq_meter_state_e;

    // Width of a counter that must hold values 0 .. n-1 (at least one bit)
    function automatic int bsg_clk_gen_pearl_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_sync_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the clk_i domain.
// Both stages clear on reset so the synchronized value starts low.
`timescale 1ps/1ps
module bsg_sync_sync #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] meta_reg;
    logic [width_p-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < width_p; gi++) begin : g_bit
            // Capture then re-capture each bit to resolve metastability
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= data_i[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign data_o = sync_reg;

endmodule

// File: rtl/bsg_clk_gen_pearl_freq_meter.sv
// Frequency meter for the pearl's monitor clock. After a start request the
// meter waits for a monitor rising edge (ARM), then counts monitor rising
// edges over a programmable number of reference cycles (COUNT) and presents
// the result through a valid/yumi handshake (DONE).
`timescale 1ps/1ps
module bsg_clk_gen_pearl_freq_meter
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int window_width_p = bsg_clk_gen_pearl_freq_window_width_gp,
    parameter int count_width_p  = bsg_clk_gen_pearl_freq_count_width_gp,
    parameter int arm_timeout_p  = 1024
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      monitor_i,
    input  logic                      start_v_i,
    output logic                      start_ready_o,
    input  logic [window_width_p-1:0] window_i,
    output logic                      result_v_o,
    input  logic                      result_yumi_i,
    output logic [count_width_p-1:0]  count_o,
    output logic                      sat_o,
    output logic                      timeout_o,
    output logic                      busy_o
);

    localparam int timer_width_lp = bsg_clk_gen_pearl_cnt_width(arm_timeout_p);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(arm_timeout_p - 1);
    localparam logic [window_width_p-1:0] win_last_lp   = window_width_p'(1);

    bsg_clk_gen_pearl_freq_meter_state_e state_reg, state_next;

    logic                      monitor_sync;
    logic                      monitor_prev_reg;
    logic                      mon_edge;
    logic [window_width_p-1:0] window_reg;
    logic [window_width_p-1:0] win_cnt_reg;
    logic [timer_width_lp-1:0] timer_reg;
    logic [count_width_p-1:0]  count_reg;
    logic                      sat_reg;
    logic                      timeout_reg;

    bsg_sync_sync #(
        .width_p (1)
    ) monitor_sync_inst (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (monitor_i),
        .data_o  (monitor_sync)
    );

    // Previous synchronized value, used to turn the level into a one-cycle rise pulse
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            monitor_prev_reg <= 1'b0;
        end else begin
            monitor_prev_reg <= monitor_sync;
        end
    end

    assign mon_edge = monitor_sync & ~monitor_prev_reg;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= e_freq_idle;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; an arming edge takes priority over the arm timeout
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            e_freq_idle: begin
                if (start_v_i) begin
                    state_next = (window_i == '0) ? e_freq_done : e_freq_arm;
                end
            end
            e_freq_arm: begin
                if (mon_edge) begin
                    state_next = e_freq_count;
                end else if (timer_reg == timer_last_lp) begin
                    state_next = e_freq_done;
                end
            end
            e_freq_count: begin
                if (win_cnt_reg == win_last_lp) begin
                    state_next = e_freq_done;
                end
            end
            e_freq_done: begin
                if (result_yumi_i) begin
                    state_next = e_freq_idle;
                end
            end
            default: state_next = e_freq_idle;
        endcase
    end

    // Measurement datapath: window latch, arm timer, window countdown, edge count
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            window_reg  <= '0;
            win_cnt_reg <= '0;
            timer_reg   <= '0;
            count_reg   <= '0;
            sat_reg     <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                e_freq_idle: begin
                    if (start_v_i) begin
                        window_reg  <= window_i;
                        timer_reg   <= '0;
                        count_reg   <= '0;
                        sat_reg     <= 1'b0;
                        timeout_reg <= 1'b0;
                    end
                end
                e_freq_arm: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (mon_edge) begin
                        // The arming edge only opens the window; it is not counted
                        win_cnt_reg <= window_reg;
                    end else if (timer_reg == timer_last_lp) begin
                        timeout_reg <= 1'b1;
                    end
                end
                e_freq_count: begin
                    win_cnt_reg <= win_cnt_reg - 1'b1;
                    if (mon_edge) begin
                        if (&count_reg) begin
                            sat_reg <= 1'b1;
                        end else begin
                            count_reg <= count_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    // DONE holds the result stable until it is consumed
                end
            endcase
        end
    end

    // Status outputs decoded from the state register only
    always_comb begin
        start_ready_o = 1'b0;
        result_v_o    = 1'b0;
        busy_o        = 1'b0;
        case (state_reg)
            e_freq_idle:  start_ready_o = 1'b1;
            e_freq_arm:   busy_o        = 1'b1;
            e_freq_count: busy_o        = 1'b1;
            e_freq_done:  result_v_o    = 1'b1;
            default:      start_ready_o = 1'b0;
        endcase
    end

    assign count_o   = count_reg;
    assign sat_o     = sat_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_meter.sv
// Bench for the pearl frequency meter: a 16-bit-count instance for most
// scenarios and a 4-bit-count instance for saturation. The monitor is either
// a free-running generator (random periods) or driven cycle-by-cycle so that
// edge placement, and therefore counts and latencies, are known exactly.
`timescale 1ps/1ps
module tb_bsg_clk_gen_pearl_freq_meter;

    localparam int clk_period_lp  = 1000;
    localparam int arm_timeout_lp = 1024;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic mon_gen    = 1'b0;
    logic mon_man    = 1'b0;
    logic mon_manual = 1'b1;
    logic mon_en     = 1'b0;
    int   mon_half   = 4000;
    logic monitor;

    assign monitor = mon_manual ? mon_man : mon_gen;

    logic        start_v = 1'b0;
    logic        yumi    = 1'b0;
    logic [15:0] window  = '0;
    logic        start_ready, result_v, sat, timeout, busy;
    logic [15:0] count;

    logic        s_start_v = 1'b0;
    logic        s_yumi    = 1'b0;
    logic [15:0] s_window  = '0;
    logic        s_start_ready, s_result_v, s_sat, s_timeout, s_busy;
    logic [3:0]  s_count;

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    logic result_v_prev = 1'b0;

    bsg_clk_gen_pearl_freq_meter #(
        .window_width_p (16),
        .count_width_p  (16),
        .arm_timeout_p  (arm_timeout_lp)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .monitor_i     (monitor),
        .start_v_i     (start_v),
        .start_ready_o (start_ready),
        .window_i      (window),
        .result_v_o    (result_v),
        .result_yumi_i (yumi),
        .count_o       (count),
        .sat_o         (sat),
        .timeout_o     (timeout),
        .busy_o        (busy)
    );

    bsg_clk_gen_pearl_freq_meter #(
        .window_width_p (16),
        .count_width_p  (4),
        .arm_timeout_p  (arm_timeout_lp)
    ) dut_sat (
        .clk_i         (clk),
        .reset_i       (reset),
        .monitor_i     (monitor),
        .start_v_i     (s_start_v),
        .start_ready_o (s_start_ready),
        .window_i      (s_window),
        .result_v_o    (s_result_v),
        .result_yumi_i (s_yumi),
        .count_o       (s_count),
        .sat_o         (s_sat),
        .timeout_o     (s_timeout),
        .busy_o        (s_busy)
    );

    always #(clk_period_lp / 2) clk = ~clk;

    // Free-running monitor; toggles land 37 ps past a 100 ps grid, never on a clk edge
    always begin
        if (!mon_en) begin
            mon_gen = 1'b0;
            #100;
        end else begin
            #137;
            mon_gen = ~mon_gen;
            #(mon_half - 137);
        end
    end

    // Count rising edges of result_v on the main instance
    always @(negedge clk) begin
        if (result_v && !result_v_prev) pulses <= pulses + 1;
        result_v_prev <= result_v;
    end

    initial begin
        #(100_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic valid_of(input bit sel);
        return sel ? s_result_v : result_v;
    endfunction

    function automatic int count_of(input bit sel);
        return sel ? int'(s_count) : int'(count);
    endfunction

    // Present a start for one cycle; returns at the negedge of the cycle after acceptance
    task automatic drive_start(input bit sel, input logic [15:0] w);
        @(negedge clk);
        if (sel) begin s_start_v = 1'b1; s_window = w; end
        else     begin start_v   = 1'b1; window   = w; end
        @(negedge clk);
        s_start_v = 1'b0;
        start_v   = 1'b0;
    endtask

    // Cycles are counted from the acceptance cycle (the first check is cycle 1)
    task automatic wait_done(input bit sel, input int budget, output int cycles, output bit ok);
        cycles = 1;
        ok     = 1'b0;
        while (cycles <= budget) begin
            if (valid_of(sel)) begin ok = 1'b1; break; end
            @(negedge clk);
            cycles++;
        end
    endtask

    // Start, then drive the monitor by hand: rise in cycle rise_at, then either a
    // 5-cycle pulse train (2 high, 3 low) or held high
    task automatic run_manual(input bit sel, input logic [15:0] w, input int rise_at, input bit pulse,
                              input int budget, output int cycles, output bit ok);
        mon_man    = 1'b0;
        mon_manual = 1'b1;
        repeat (4) @(negedge clk);
        drive_start(sel, w);
        cycles = 1;
        ok     = 1'b0;
        while (cycles <= budget) begin
            if (valid_of(sel)) begin ok = 1'b1; break; end
            if (cycles >= rise_at) mon_man = pulse ? (((cycles - rise_at) % 5) < 2) : 1'b1;
            @(negedge clk);
            cycles++;
        end
        mon_man = 1'b0;
    endtask

    // Consume the result presented in the current cycle
    task automatic take_result(input bit sel);
        if (sel) s_yumi = 1'b1; else yumi = 1'b1;
        @(negedge clk);
        s_yumi = 1'b0;
        yumi   = 1'b0;
    endtask

    task automatic use_generator(input int half);
        mon_half   = half;
        mon_en     = 1'b1;
        mon_manual = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got %b want 1", start_ready); end
        checks++; if (result_v !== 1'b0) begin errors++; $display("FAIL reset_result_v: got %b want 0", result_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (sat !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b timeout=%b want 0/0", sat, timeout); end
        #200 reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (start_ready !== 1'b1 || busy !== 1'b0 || result_v !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle: got ready=%b busy=%b valid=%b want 1/0/0", start_ready, busy, result_v);
        end
        $display("reset: ready=%b busy=%b valid=%b count=%0d", start_ready, busy, result_v, count);
    endtask

    task automatic test_basic_count;
        int cyc; bit ok;
        use_generator(4000);
        drive_start(1'b0, 16'd800);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(1'b0, 1000, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: no result within 1000 cycles"); end
        checks++; if (count_of(1'b0) < 99 || count_of(1'b0) > 101) begin errors++; $display("FAIL basic_count: got %0d want 99..101", count); end
        checks++; if (sat !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL basic_flags: got sat=%b timeout=%b want 0/0", sat, timeout); end
        checks++; if (busy !== 1'b0 || start_ready !== 1'b0) begin errors++; $display("FAIL basic_done_status: got busy=%b ready=%b want 0/0", busy, start_ready); end
        $display("basic: window=800 count=%0d sat=%b timeout=%b cycles=%0d", count, sat, timeout, cyc);
        take_result(1'b0);
        checks++; if (start_ready !== 1'b1 || result_v !== 1'b0) begin errors++; $display("FAIL basic_yumi: got ready=%b valid=%b want 1/0", start_ready, result_v); end
    endtask

    task automatic test_random_count;
        int cyc, w, half, expv; bit ok;
        for (int i = 0; i < 4; i++) begin
            half = 100 * int'($urandom_range(26, 75));
            w    = int'($urandom_range(1, 500));
            use_generator(half);
            expv = (w * clk_period_lp) / (2 * half);
            drive_start(1'b0, w[15:0]);
            wait_done(1'b0, w + 100, cyc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL random_done: no result for window=%0d", w); end
            checks++; if (count_of(1'b0) < expv - 1 || count_of(1'b0) > expv + 1 || timeout !== 1'b0 || sat !== 1'b0) begin
                errors++; $display("FAIL random_count: window=%0d period=%0d got count=%0d timeout=%b sat=%b want %0d+-1 0 0", w, 2 * half, count, timeout, sat, expv);
            end
            $display("random: window=%0d period=%0dps count=%0d expect~%0d", w, 2 * half, count, expv);
            take_result(1'b0);
        end
    endtask

    task automatic test_exact_window;
        int cyc, w; bit ok;
        int widths[5];
        widths[0] = 1; widths[1] = 5; widths[2] = 10; widths[3] = 37;
        widths[4] = int'($urandom_range(2, 120));
        foreach (widths[k]) begin
            w = widths[k];
            run_manual(1'b0, w[15:0], 3, 1'b1, w + 40, cyc, ok);
            checks++; if (!ok || cyc != w + 6) begin errors++; $display("FAIL exact_latency: window=%0d got %0d cycles want %0d", w, cyc, w + 6); end
            checks++; if (count_of(1'b0) != w / 5 || timeout !== 1'b0) begin errors++; $display("FAIL exact_count: window=%0d got %0d timeout=%b want %0d 0", w, count, timeout, w / 5); end
            $display("exact: window=%0d count=%0d cycles=%0d", w, count, cyc);
            take_result(1'b0);
        end
    endtask

    task automatic test_timeout;
        int cyc; bit ok;
        run_manual(1'b0, 16'd50, 1_000_000, 1'b1, 1200, cyc, ok);
        checks++; if (!ok || cyc != arm_timeout_lp + 1) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc, arm_timeout_lp + 1); end
        checks++; if (timeout !== 1'b1 || count !== 16'd0 || sat !== 1'b0) begin errors++; $display("FAIL timeout_flags: got timeout=%b count=%0d sat=%b want 1 0 0", timeout, count, sat); end
        $display("timeout: cycles=%0d timeout=%b count=%0d", cyc, timeout, count);
        take_result(1'b0);
        // Edge lands in the very cycle the timer expires: the edge must win
        run_manual(1'b0, 16'd5, arm_timeout_lp - 2, 1'b0, 1200, cyc, ok);
        checks++; if (!ok || cyc != arm_timeout_lp + 6 || timeout !== 1'b0) begin
            errors++; $display("FAIL edge_wins: got cycles=%0d timeout=%b want %0d 0", cyc, timeout, arm_timeout_lp + 6);
        end
        $display("edge_wins: cycles=%0d timeout=%b count=%0d", cyc, timeout, count);
        take_result(1'b0);
        // Edge one cycle too late: timeout has already fired
        run_manual(1'b0, 16'd5, arm_timeout_lp - 1, 1'b0, 1200, cyc, ok);
        checks++; if (!ok || cyc != arm_timeout_lp + 1 || timeout !== 1'b1) begin
            errors++; $display("FAIL edge_late: got cycles=%0d timeout=%b want %0d 1", cyc, timeout, arm_timeout_lp + 1);
        end
        $display("edge_late: cycles=%0d timeout=%b", cyc, timeout);
        take_result(1'b0);
    endtask

    task automatic test_zero_window;
        int p0;
        mon_manual = 1'b1;
        mon_man    = 1'b0;
        repeat (4) @(negedge clk);
        #1 p0 = pulses;
        @(negedge clk);
        start_v = 1'b1;
        window  = 16'd0;
        @(negedge clk);
        checks++; if (result_v !== 1'b1 || count !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_window: got valid=%b count=%0d busy=%b want 1 0 0", result_v, count, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (result_v !== 1'b1 || start_ready !== 1'b0) begin
                errors++; $display("FAIL zero_hold: cycle %0d got valid=%b ready=%b want 1 0", i, result_v, start_ready);
            end
        end
        take_result(1'b0);
        start_v = 1'b0;
        checks++; if (start_ready !== 1'b1 || result_v !== 1'b0) begin errors++; $display("FAIL zero_yumi: got ready=%b valid=%b want 1 0", start_ready, result_v); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL zero_pulses: got %0d result pulses want 1", pulses - p0); end
        $display("zero_window: count=%0d pulses=%0d", count, pulses - p0);
    endtask

    task automatic test_saturation;
        int cyc; bit ok;
        run_manual(1'b1, 16'd75, 3, 1'b1, 200, cyc, ok);
        checks++; if (!ok || s_count !== 4'd15 || s_sat !== 1'b0) begin errors++; $display("FAIL sat_edge15: got count=%0d sat=%b want 15 0", s_count, s_sat); end
        $display("sat_exact: window=75 count=%0d sat=%b", s_count, s_sat);
        take_result(1'b1);
        run_manual(1'b1, 16'd80, 3, 1'b1, 200, cyc, ok);
        checks++; if (!ok || s_count !== 4'd15 || s_sat !== 1'b1) begin errors++; $display("FAIL sat_edge16: got count=%0d sat=%b want 15 1", s_count, s_sat); end
        $display("sat_exact: window=80 count=%0d sat=%b", s_count, s_sat);
        take_result(1'b1);
        use_generator(2500);
        drive_start(1'b1, 16'd200);
        wait_done(1'b1, 400, cyc, ok);
        checks++; if (!ok || s_count !== 4'd15 || s_sat !== 1'b1 || s_timeout !== 1'b0) begin
            errors++; $display("FAIL sat_free: got count=%0d sat=%b timeout=%b want 15 1 0", s_count, s_sat, s_timeout);
        end
        $display("sat_free: window=200 count=%0d sat=%b", s_count, s_sat);
        take_result(1'b1);
    endtask

    task automatic test_reset_mid;
        int cyc; bit ok;
        use_generator(4000);
        drive_start(1'b0, 16'd800);
        repeat (200) @(negedge clk);
        checks++; if (busy !== 1'b1 || count_of(1'b0) == 0) begin errors++; $display("FAIL mid_busy: got busy=%b count=%0d want 1 nonzero", busy, count); end
        #100 reset = 1'b1;
        #100;
        checks++; if (busy !== 1'b0 || result_v !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset_status: got busy=%b valid=%b ready=%b want 0 0 1", busy, result_v, start_ready);
        end
        checks++; if (count !== 16'd0 || sat !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL mid_reset_result: got count=%0d sat=%b timeout=%b want 0 0 0", count, sat, timeout);
        end
        #200 reset = 1'b0;
        repeat (5) @(negedge clk);
        drive_start(1'b0, 16'd800);
        wait_done(1'b0, 1000, cyc, ok);
        checks++; if (!ok || count_of(1'b0) < 99 || count_of(1'b0) > 101) begin errors++; $display("FAIL mid_rerun: got count=%0d want 99..101", count); end
        $display("reset_mid: rerun count=%0d", count);
        take_result(1'b0);
    endtask

    task automatic test_back_to_back;
        int cyc, w, half, expv, p0; bit ok;
        half = 100 * int'($urandom_range(26, 40));
        w    = int'($urandom_range(20, 100));
        expv = (w * clk_period_lp) / (2 * half);
        use_generator(half);
        #1 p0 = pulses;
        drive_start(1'b0, w[15:0]);
        wait_done(1'b0, w + 100, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first: no result"); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (count_of(1'b0) < expv - 1 || count_of(1'b0) > expv + 1) begin
                errors++; $display("FAIL b2b_count: result %0d got %0d want %0d+-1", i, count, expv);
            end
            $display("b2b: result=%0d window=%0d count=%0d", i, w, count);
            yumi = 1'b1;
            @(negedge clk);
            yumi = 1'b0;
            checks++; if (start_ready !== 1'b1 || result_v !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b valid=%b want 1 0", start_ready, result_v); end
            if (i < 2) begin
                start_v = 1'b1;
                window  = w[15:0];
                @(negedge clk);
                start_v = 1'b0;
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
                wait_done(1'b0, w + 100, cyc, ok);
                checks++; if (!ok) begin errors++; $display("FAIL b2b_done: result %0d missing", i + 1); end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (pulses - p0 != 3) begin errors++; $display("FAIL b2b_pulses: got %0d result pulses want 3", pulses - p0); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_random_count();
        test_exact_window();
        test_timeout();
        test_zero_window();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_clk_gen_pearl_freq_meter.md
# bsg_clk_gen_pearl_freq_meter

Measures the frequency of the clock generated by `bsg_clk_gen_pearl`. It counts rising edges of the pearl's `clk_monitor_o` (a divided-down copy of `clk_o`) over a programmable number of reference-clock cycles. It sits directly downstream of the pearl: on the PCB testbench it replaces ad-hoc period watching, and on chip it feeds a status/readback path. The result is returned through a valid/yumi handshake.

## Interface
Parameters:
- `window_width_p`, 16: width of the measurement window count, in reference cycles.
- `count_width_p`, 16: width of the edge count result.
- `arm_timeout_p`, 1024: reference cycles to wait for the first monitor edge before giving up. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`, in, 1: reference clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `monitor_i`, in, 1: asynchronous monitor clock from the pearl. Its frequency must be < `clk_i`/4.
- `start_v_i`, in, 1: request a measurement.
- `start_ready_o`, out, 1: high only in IDLE.
- `window_i`, in, `window_width_p`: window length. Sampled when `start_v_i & start_ready_o`.
- `result_v_o`, out, 1: result valid (DONE state).
- `result_yumi_i`, in, 1: result consumed. Legal only while `result_v_o` is high.
- `count_o`, out, `count_width_p`: rising edges counted in the window.
- `sat_o`, out, 1: the count saturated.
- `timeout_o`, out, 1: no edge was seen during ARM.
- `busy_o`, out, 1: state is ARM or COUNT.

## Operation
- **Input path.** `monitor_i` passes through a 2-flop synchronizer, then a previous-value register. `edge` = sync & ~prev. All three flops reset to 0.
- **States:** IDLE, ARM, COUNT, DONE.
- **IDLE.** On `start_v_i`:
  - latch `window_i`;
  - clear the count, `sat` and `timeout`;
  - go to ARM. If `window_i` == 0, go straight to DONE with count 0.
- **ARM** aligns the window to a monitor edge.
  - The timeout counter starts at 0 and increments each cycle.
  - On `edge`: go to COUNT and load the window counter with the latched window. This arming edge is not counted.
  - When the timeout counter reaches `arm_timeout_p`-1 with no edge: go to DONE with `timeout`=1 and count 0.
  - If `edge` and the timeout fire in the same cycle, `edge` wins.
- **COUNT** lasts exactly `window` cycles.
  - Each cycle the window counter decrements, and count += `edge`.
  - An edge in the final cycle is counted.
  - The count saturates at all-ones. `sat` goes to 1 when an edge arrives with the count already all-ones.
  - When the window counter reaches 1 (after that cycle's update), go to DONE.
- **DONE.** `result_v_o`=1 and the result registers are held stable. On `result_yumi_i`, go to IDLE. `start_v_i` is ignored outside IDLE.
- **Asynchronous reset** at any time, including mid-measurement:
  - state goes to IDLE;
  - `count_o`=0, `sat_o`=0, `timeout_o`=0, `result_v_o`=0, `busy_o`=0, `start_ready_o`=1 once reset deasserts.
- **Spurious edge at reset release.** If `monitor_i` is high when reset releases, one `edge` pulse occurs. It is harmless unless ARM is entered within 3 cycles, so the bench waits ≥ 4 cycles before the first start.

## Timing
- A `monitor_i` rise is seen as `edge` 2–3 `clk_i` cycles later.
- Start is accepted at edge N; the state is ARM from N+1.
- The arming edge in ARM at cycle A puts COUNT in cycles A+1 … A+window. DONE (`result_v_o`=1) is at A+window+1.
- Zero window: `result_v_o`=1 the cycle after acceptance.
- Timeout: `result_v_o`=1 exactly `arm_timeout_p`+1 cycles after acceptance.
- With `result_yumi_i` at cycle D, IDLE (`start_ready_o`=1) is at D+1. The next start can be accepted at D+1.
- All outputs are registered or decoded from the state register only. There is no combinational path from `result_yumi_i` or `start_v_i` to any output.
- Expected count is ≈ window·f_mon/f_clk, ±1.

## Structure
- Add to `bsg_clk_gen_pearl_pkg`:
  - the state enum `bsg_clk_gen_pearl_freq_meter_state_e` (IDLE, ARM, COUNT, DONE);
  - default width constants `bsg_clk_gen_pearl_freq_window_width_gp` and `bsg_clk_gen_pearl_freq_count_width_gp`.
- The synchronizer is one sub-module: `bsg_sync_sync` (width 1). Everything else is flat.
- PCB testbench integration: connect `monitor_i` to `IC.clk_monitor_o`. The testbench drives start and yumi.

## Test plan
- **Basic count.** `clk_i` period 1000 ps, `monitor_i` period 8000 ps, `window_i`=800 → `count_o` ∈ {99, 100, 101}, `sat_o`=0, `timeout_o`=0.
- **Timeout.** `monitor_i` held at 0, `arm_timeout_p`=1024 → `result_v_o` rises 1025 cycles after acceptance with `timeout_o`=1 and `count_o`=0.
- **Zero window.** `window_i`=0 → `result_v_o` the next cycle with `count_o`=0. `start_v_i` held high in DONE creates no new measurement until yumi.
- **Saturation.** `count_width_p`=4, `monitor_i` period 5000 ps, `window_i`=200 → `count_o`=15, `sat_o`=1.
- **Reset mid-operation.** Assert `reset_i` mid-COUNT for 300 ps, not aligned to a clock edge → outputs go to their reset values immediately. A fresh measurement of the basic-count case then returns 99–101.
- **Back-to-back.** Yumi and a new start in consecutive cycles, repeated 3 times → three valid results, with no lost or duplicated `result_v_o` pulses.
